vdrive_linebuf: RTL and testbench
=================================

Name: vdrive_linebuf

Overview:
- Parametrised, line-buffered successor to the studio video driver.
- Reads the CPU-side VRAM over a synchronous read port and scales it to the hvsync raster in one of two selectable modes: lores 64x32 at x4, or hires 128x64 at x2.
- Ping-pong line buffers: each source row is prefetched during the scanline before it is shown, so VRAM reads never depend on raster timing.
- Sits between vram's vdrive port and the RGB output logic in the top level.

Parameters:
- VRAM_W, 128, hires source width in pixels; lores width is VRAM_W/2.
- VRAM_H, 64, hires source height in rows; lores height is VRAM_H/2.
- PIX_BITS, 2, bits per pixel.
- H_ACTIVE, 256, visible pixels per line; must equal VRAM_W*2.
- V_OFFSET, 56, first raster line of the image.
- POS_W, 9, width of the hvsync hpos/vpos inputs.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- hires  in  1  mode request; sampled only at frame start
- hvsync_hpos  in  POS_W  raster column; advances by 1 per clk and wraps to 0 each line
- hvsync_vpos  in  POS_W  raster line
- vram_rd  out  1  read strobe
- vram_hpos  out  7  source column
- vram_vpos  out  6  source row
- vram_pixel  in  PIX_BITS  read data, valid 1 clk after the strobe
- hvsync_pixel  out  PIX_BITS  scaled pixel, registered
- fetch_busy  out  1  fetch FSM not in IDLE
- fetch_err  out  1  sticky overrun flag

Behaviour:
- Reset (asserted low, async): all outputs 0; FSM IDLE; mode_q=0; both buffer-valid flags cleared; display select sel=0. Buffer contents are not cleared.
- line_start = (hvsync_hpos==0).
- Frame latch: at line_start with vpos==0, mode_q<=hires. S=2, W=VRAM_W, R=VRAM_H when mode_q=1; otherwise S=4, W=VRAM_W/2, R=VRAM_H/2. Image height R*S = 2*VRAM_H in both modes.
- Fetch trigger: line_start with vpos == V_OFFSET + r*S - 1, for r in 0..R-1. The target is the back buffer (!sel).
- FSM IDLE -> ISSUE on trigger.
- ISSUE: vram_rd=1, vram_hpos=col, vram_vpos=r, for col 0..W-1, one per clk.
- Each returned pixel is written to back[col_d], where col_d is col delayed 1 clk.
- After the last issue, ISSUE -> DRAIN for 1 clk to capture the final datum. DRAIN -> IDLE and sets the back-valid flag.
- A fetch takes W+1 clks. vram_hpos/vram_vpos hold their last values when vram_rd=0.
- Swap: line_start with vpos == V_OFFSET + r*S (first line of row r) toggles sel. The new front-valid flag is taken from the fetch. The old front-valid flag is cleared.
- Overrun: a trigger or swap while the FSM is not IDLE sets fetch_err (cleared only by reset). The in-flight fetch aborts to IDLE with back-valid=0. A trigger then restarts the fetch from col 0. A swap with back-valid=0 displays 0s for that row.
- Pixel path, 1 clk latency: hvsync_pixel <= front[hpos/S] when hpos < H_ACTIVE, V_OFFSET <= vpos < V_OFFSET+R*S, and front-valid=1; otherwise 0.
- hpos/S is a shift by 1 (hires) or 2 (lores).
- Outside the image region the FSM never triggers.
- The mode latch and sel logic ignore vpos values past the raster bottom.
- Reset mid-fetch: immediate IDLE, no further vram_rd.
- After reset, no pixel reaches the output until the first complete fetch-plus-swap.
- Implementation uses two buffers of VRAM_W x PIX_BITS, a column counter, a row counter, a 1-clk data-capture delay, and mode/valid/sel state.

Test Plan:
- Hires, VRAM pixel = col[1:0] at row 0; raster reaches vpos=55, hpos=0 -> vram_rd high for exactly 128 clks, cols 0..127, row 0; fetch_busy high 129 clks; at vpos=56 the hvsync_pixel sequence for hpos 0..255 is 0,0,1,1,2,2,3,3,... one clk after each hpos.
- Lores, row r filled with 3: trigger lines are 55,59,...,179; each fetch is 64 reads of row r; every displayed pixel in vpos 56..183 is 3; vpos 184 and vpos 55 output 0.
- hires toggled 0->1 at vpos=100 -> geometry stays lores until next vpos=0, line_start; the following frame fetches 128 columns with row trigger at line 57 after the one at 55.
- Force hvsync_hpos to 0 again 20 clks into a fetch (early trigger/swap) -> fetch_err=1 and stays 1; the aborted row displays 0; the next row displays correctly.
- Reset low for 1 clk during ISSUE at col 40 -> vram_rd, hvsync_pixel, fetch_busy, fetch_err all 0 immediately; output stays 0 until the next full fetch+swap completes.
- hpos 256..H_TOTAL-1 and vpos<56 -> hvsync_pixel=0 regardless of buffer contents.

Source files
------------

// File: rtl/vdrive_linebuf.sv
// Line-buffered VRAM-to-raster scaler (lores 64x32 x4 / hires 128x64 x2) with ping-pong row buffers.
// Latency: hvsync_pixel is registered, 1 clk after hpos; a row fetch takes W+1 clks.
// Backpressure: none; VRAM reads are prefetched one line ahead, and a late fetch is aborted and flagged in fetch_err.
module vdrive_linebuf #(
    parameter int VRAM_W   = 128,
    parameter int VRAM_H   = 64,
    parameter int PIX_BITS = 2,
    parameter int H_ACTIVE = 256,
    parameter int V_OFFSET = 56,
    parameter int POS_W    = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hires,
    input  logic [POS_W-1:0]            hvsync_hpos,
    input  logic [POS_W-1:0]            hvsync_vpos,
    output logic                        vram_rd,
    output logic [$clog2(VRAM_W)-1:0]   vram_hpos,
    output logic [$clog2(VRAM_H)-1:0]   vram_vpos,
    input  logic [PIX_BITS-1:0]         vram_pixel,
    output logic [PIX_BITS-1:0]         hvsync_pixel,
    output logic                        fetch_busy,
    output logic                        fetch_err
);
    localparam int CW    = $clog2(VRAM_W);
    localparam int RW    = $clog2(VRAM_H);
    localparam int IMG_H = 2 * VRAM_H;
    localparam logic [POS_W:0] TRG_BASE = (POS_W+1)'(V_OFFSET - 1);
    localparam logic [POS_W:0] SWP_BASE = (POS_W+1)'(V_OFFSET);
    localparam logic [POS_W:0] IMG_LIM  = (POS_W+1)'(IMG_H);
    localparam logic [POS_W:0] H_LIM    = (POS_W+1)'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    logic [PIX_BITS-1:0] buf0 [VRAM_W];
    logic [PIX_BITS-1:0] buf1 [VRAM_W];

    state_t          state;
    logic            mode_q;
    logic            sel;
    logic [1:0]      buf_vld;
    logic            cap_vld;
    logic [CW-1:0]   col_d;

    logic            line_start;
    logic [POS_W:0]  vpos_x;
    logic [POS_W:0]  trg_rel;
    logic [POS_W:0]  swp_rel;
    logic            trg_in;
    logic            swp_in;
    logic            trigger;
    logic            swap;
    logic [RW-1:0]   trg_row;
    logic [CW-1:0]   last_col;
    logic            sel_eff;
    logic [POS_W-1:0] hpos_sh;
    logic [CW-1:0]   hidx;
    logic [PIX_BITS-1:0] front_pix;
    logic            show;

    assign line_start = (hvsync_hpos == '0);
    assign vpos_x     = {1'b0, hvsync_vpos};
    assign trg_rel    = vpos_x - TRG_BASE;
    assign swp_rel    = vpos_x - SWP_BASE;
    assign trg_in     = (vpos_x >= TRG_BASE) && (trg_rel < IMG_LIM);
    assign swp_in     = (vpos_x >= SWP_BASE) && (swp_rel < IMG_LIM);

    // A source row spans S raster lines; rows start where rel is a multiple of S.
    assign trigger  = line_start && trg_in && (mode_q ? !trg_rel[0] : (trg_rel[1:0] == 2'b00));
    assign swap     = line_start && swp_in && (mode_q ? !swp_rel[0] : (swp_rel[1:0] == 2'b00));
    assign trg_row  = mode_q ? RW'(trg_rel >> 1) : RW'(trg_rel >> 2);
    assign last_col = mode_q ? CW'(VRAM_W - 1) : CW'(VRAM_W/2 - 1);

    assign fetch_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            sel       <= 1'b0;
            buf_vld   <= 2'b00;
            cap_vld   <= 1'b0;
            col_d     <= '0;
            vram_rd   <= 1'b0;
            vram_hpos <= '0;
            vram_vpos <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (line_start && hvsync_vpos == '0)
                mode_q <= hires;
            if (trigger) begin
                if (state != IDLE)
                    fetch_err <= 1'b1;
                state         <= ISSUE;
                vram_rd       <= 1'b1;
                vram_hpos     <= '0;
                vram_vpos     <= trg_row;
                buf_vld[~sel] <= 1'b0;
                cap_vld       <= 1'b0;
            end else if (swap) begin
                // Unfinished fetch is dropped; its buffer becomes front with valid=0, so the row shows black.
                if (state != IDLE)
                    fetch_err <= 1'b1;
                state        <= IDLE;
                vram_rd      <= 1'b0;
                cap_vld      <= 1'b0;
                sel          <= ~sel;
                buf_vld[sel] <= 1'b0;
            end else begin
                case (state)
                    ISSUE: begin
                        cap_vld <= 1'b1;
                        col_d   <= vram_hpos;
                        if (vram_hpos == last_col) begin
                            state   <= DRAIN;
                            vram_rd <= 1'b0;
                        end else begin
                            vram_hpos <= vram_hpos + 1'b1;
                        end
                    end
                    DRAIN: begin
                        cap_vld       <= 1'b0;
                        state         <= IDLE;
                        buf_vld[~sel] <= 1'b1;
                    end
                    default: begin
                        cap_vld <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    // Returned data always lands in the back buffer (!sel).
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            if (sel)
                buf0[col_d] <= vram_pixel;
            else
                buf1[col_d] <= vram_pixel;
        end
    end

    // On a swap line the pixel at hpos 0 must already come from the new front buffer.
    assign sel_eff   = swap ? ~sel : sel;
    assign hpos_sh   = mode_q ? (hvsync_hpos >> 1) : (hvsync_hpos >> 2);
    assign hidx      = CW'(hpos_sh);
    assign front_pix = sel_eff ? buf1[hidx] : buf0[hidx];
    assign show      = ({1'b0, hvsync_hpos} < H_LIM) && swp_in && buf_vld[sel_eff];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hvsync_pixel <= '0;
        else
            hvsync_pixel <= show ? front_pix : '0;
    end
endmodule

// File: tb/tb_vdrive_linebuf.sv
// Directed bench for vdrive_linebuf: line-level vector table plus hand sequences for overrun and reset.
module tb_vdrive_linebuf;
    localparam int H_TOTAL = 272;

    logic       clk = 1'b0;
    logic       reset;
    logic       hires;
    logic [8:0] hvsync_hpos;
    logic [8:0] hvsync_vpos;
    logic       vram_rd;
    logic [6:0] vram_hpos;
    logic [5:0] vram_vpos;
    logic [1:0] vram_pixel = 2'd0;
    logic [1:0] hvsync_pixel;
    logic       fetch_busy;
    logic       fetch_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit pat   = 1'b0;

    vdrive_linebuf dut (
        .clk(clk), .reset(reset), .hires(hires),
        .hvsync_hpos(hvsync_hpos), .hvsync_vpos(hvsync_vpos),
        .vram_rd(vram_rd), .vram_hpos(vram_hpos), .vram_vpos(vram_vpos),
        .vram_pixel(vram_pixel), .hvsync_pixel(hvsync_pixel),
        .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // VRAM model: pattern 0 -> pixel = col[1:0]; pattern 1 -> constant 3.
    always @(posedge clk)
        if (vram_rd)
            vram_pixel <= pat ? 2'd3 : vram_hpos[1:0];

    typedef struct {
        int v;
        bit hi;
        bit pt;
        int rd;
        int row;
        int kind;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string nm, input int v, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vpos %0d): got %0d, expected %0d", nm, v, act, exp);
        end
    endtask

    // kind 0: black; 1: hires col pattern; 2: all 3; 3: lores col pattern
    function automatic logic [1:0] exp_pix(input int kind, input int h);
        int p;
        p = 0;
        if (h < 256) begin
            case (kind)
                1: p = (h >> 1) & 3;
                2: p = 3;
                3: p = (h >> 2) & 3;
                default: p = 0;
            endcase
        end
        return 2'(p);
    endfunction

    task automatic line(input int v, input int h0, input int h1, input int exp_rd,
                        input int exp_busy, input int exp_row, input int kind, input bit hi);
        int rd_n;
        int busy_n;
        int seq_bad;
        int pix_bad;
        rd_n = 0; busy_n = 0; seq_bad = 0; pix_bad = 0;
        hvsync_vpos = 9'(v);
        hires = hi;
        for (int h = h0; h <= h1; h++) begin
            hvsync_hpos = 9'(h);
            @(posedge clk);
            #1;
            if (vram_rd) begin
                if (vram_hpos != 7'(rd_n) || vram_vpos != 6'(exp_row))
                    seq_bad++;
                rd_n++;
            end
            if (fetch_busy)
                busy_n++;
            if (hvsync_pixel !== exp_pix(kind, h))
                pix_bad++;
        end
        check("rd_count", v, rd_n, exp_rd);
        check("busy_count", v, busy_n, exp_busy);
        check("rd_addr_errors", v, seq_bad, 0);
        check("pixel_errors", v, pix_bad, 0);
    endtask

    task automatic apply(input int lo, input int hi_i);
        for (int i = lo; i <= hi_i; i++) begin
            pat = tbl[i].pt;
            line(tbl[i].v, 0, H_TOTAL - 1, tbl[i].rd, (tbl[i].rd != 0) ? tbl[i].rd + 1 : 0,
                 tbl[i].row, tbl[i].kind, tbl[i].hi);
        end
    endtask

    initial begin
        // hires first frame, row 0/1 col pattern
        tbl[0]  = '{v: 0,   hi: 1, pt: 0, rd: 0,   row: 0, kind: 0};
        tbl[1]  = '{v: 20,  hi: 1, pt: 0, rd: 0,   row: 0, kind: 0};
        tbl[2]  = '{v: 55,  hi: 1, pt: 0, rd: 128, row: 0, kind: 0};
        tbl[3]  = '{v: 56,  hi: 1, pt: 0, rd: 0,   row: 0, kind: 1};
        tbl[4]  = '{v: 57,  hi: 1, pt: 0, rd: 128, row: 1, kind: 1};
        tbl[5]  = '{v: 58,  hi: 1, pt: 0, rd: 0,   row: 0, kind: 1};
        tbl[6]  = '{v: 184, hi: 1, pt: 0, rd: 0,   row: 0, kind: 0};
        // hires requested mid-frame while lores: no hires trigger at 101, no swap at 102
        tbl[7]  = '{v: 101, hi: 1, pt: 1, rd: 0,   row: 0, kind: 2};
        tbl[8]  = '{v: 102, hi: 1, pt: 1, rd: 0,   row: 0, kind: 2};
        tbl[9]  = '{v: 0,   hi: 1, pt: 1, rd: 0,   row: 0, kind: 0};
        tbl[10] = '{v: 55,  hi: 1, pt: 1, rd: 128, row: 0, kind: 0};
        tbl[11] = '{v: 56,  hi: 1, pt: 1, rd: 0,   row: 0, kind: 2};
        tbl[12] = '{v: 57,  hi: 1, pt: 1, rd: 128, row: 1, kind: 2};
        // refill row 0 with col pattern before the overrun sequence
        tbl[13] = '{v: 0,   hi: 1, pt: 0, rd: 0,   row: 0, kind: 0};
        tbl[14] = '{v: 55,  hi: 1, pt: 0, rd: 128, row: 0, kind: 0};
        tbl[15] = '{v: 56,  hi: 1, pt: 0, rd: 0,   row: 0, kind: 1};

        reset = 1'b0;
        hires = 1'b0;
        hvsync_hpos = 9'd0;
        hvsync_vpos = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vram_rd", 0, int'(vram_rd), 0);
        check("reset_pixel", 0, int'(hvsync_pixel), 0);
        check("reset_busy", 0, int'(fetch_busy), 0);
        check("reset_err", 0, int'(fetch_err), 0);
        check("reset_vram_hpos", 0, int'(vram_hpos), 0);
        reset = 1'b1;

        apply(0, 6);

        // full lores frame, every row filled with 3
        pat = 1'b1;
        line(0, 0, H_TOTAL - 1, 0, 0, 0, 0, 1'b0);
        for (int v = 55; v <= 184; v++) begin
            int rd;
            rd = (v <= 179 && ((v - 55) % 4) == 0) ? 64 : 0;
            line(v, 0, H_TOTAL - 1, rd, (rd != 0) ? rd + 1 : 0, (v - 55) / 4,
                 (v >= 56 && v <= 183) ? 2 : 0, 1'b0);
        end
        check("lores_err", 184, int'(fetch_err), 0);

        apply(7, 15);

        // early swap 20 clks into the row-1 fetch
        pat = 1'b0;
        line(57, 0, 19, 20, 20, 1, 1, 1'b1);
        line(58, 0, H_TOTAL - 1, 0, 0, 0, 0, 1'b1);
        check("overrun_err_set", 58, int'(fetch_err), 1);
        line(59, 0, H_TOTAL - 1, 128, 129, 2, 0, 1'b1);
        line(60, 0, H_TOTAL - 1, 0, 0, 0, 1, 1'b1);
        check("overrun_err_sticky", 60, int'(fetch_err), 1);

        // reset pulse mid-fetch at col 40
        line(61, 0, 40, 41, 41, 3, 1, 1'b1);
        reset = 1'b0;
        #1;
        check("midreset_vram_rd", 61, int'(vram_rd), 0);
        check("midreset_pixel", 61, int'(hvsync_pixel), 0);
        check("midreset_busy", 61, int'(fetch_busy), 0);
        check("midreset_err", 61, int'(fetch_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // mode_q fell back to lores on reset
        line(62, 0, H_TOTAL - 1, 0, 0, 0, 0, 1'b1);
        line(63, 0, H_TOTAL - 1, 64, 65, 2, 0, 1'b1);
        line(64, 0, H_TOTAL - 1, 0, 0, 0, 3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
